vid_test_source: RTL

- Avalon-ST video packet generator: the transmit end of the 24-bit RGB pixel stream consumed by the image-processing pipeline.
- Emits complete frames: an optional control packet followed by a video packet.
- Pixel content is either colour bars or a solid box on black. The box moves one step per frame, so the colour classifier and bounding-box logic can be exercised without a camera.
- Sits in place of, or muxed with, the camera/decoder output ahead of the processing block.

---
 rtl/vid_test_source.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/vid_test_source.sv
// Avalon-ST video test-pattern source: 24-bit RGB colour bars or a moving box.
// Each frame is an optional control packet followed by a video packet.
// Build option: define VID_CTRL_PKT_EN to emit the 4-beat control packet
// ahead of every video packet; left undefined, frames carry video only.
module vid_test_source #(
  parameter int IMAGE_W   = 640,
  parameter int IMAGE_H   = 480,
  parameter int BAR_W     = 80,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_Y     = 100,
  parameter int BOX_STEP  = 4,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pattern_sel,
  input  logic [23:0] box_col,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, VID_PIX, GAP} state_t;

  localparam logic [10:0] XMAX    = 11'(IMAGE_W - 1);
  localparam logic [10:0] YMAX    = 11'(IMAGE_H - 1);
  localparam logic [10:0] BARM    = 11'(BAR_W - 1);
  localparam logic [11:0] BOX_LIM = 12'(IMAGE_W - BOX_SIZE);
  localparam logic [11:0] STEP12  = 12'(BOX_STEP);
  localparam logic [11:0] SIZE12  = 12'(BOX_SIZE);
  localparam logic [11:0] BOXY12  = 12'(BOX_Y);
  localparam logic [15:0] GAPM    = 16'(FRAME_GAP - 1);

`ifdef VID_CTRL_PKT_EN
  localparam logic [15:0] W16 = 16'(IMAGE_W);
  localparam logic [15:0] H16 = 16'(IMAGE_H);

  // Control packet payload: one nibble of width/height per colour symbol.
  function automatic logic [23:0] ctrl_beat(input logic [1:0] n);
    case (n)
      2'd0:    ctrl_beat = {4'h0, W16[7:4],  4'h0, W16[11:8],  4'h0, W16[15:12]};
      2'd1:    ctrl_beat = {4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]};
      default: ctrl_beat = {4'h0, 4'h3,      4'h0, H16[3:0],   4'h0, H16[7:4]};
    endcase
  endfunction
`endif

  function automatic logic [23:0] bar_col(input logic [2:0] b);
    case (b)
      3'd0:    bar_col = 24'hFFFFFF;
      3'd1:    bar_col = 24'hFFFF00;
      3'd2:    bar_col = 24'h00FFFF;
      3'd3:    bar_col = 24'h00FF00;
      3'd4:    bar_col = 24'hFF00FF;
      3'd5:    bar_col = 24'hFF0000;
      3'd6:    bar_col = 24'h0000FF;
      default: bar_col = 24'h000000;
    endcase
  endfunction

  state_t      state, nxt_state;
  logic [10:0] x, y, bar_cnt, box_x;
  logic [10:0] nxt_x, nxt_y, nxt_bar_cnt, nxt_box_x;
  logic [2:0]  bar_idx, nxt_bar_idx;
  logic [1:0]  cbeat, nxt_cbeat;
  logic [15:0] gap_cnt, nxt_gap_cnt, nxt_frame_count;
  logic        pat, nxt_pat;
  logic [23:0] nxt_data;
  logic        nxt_valid, nxt_sop, nxt_eop, nxt_busy;
  logic        xfer;

  // Raster position of the following pixel, used when the current one transfers.
  logic [10:0] px, py, pbar_cnt;
  logic [2:0]  pbar_idx;
  logic [11:0] bx_step;

  // Pixel colour for a given position; box_col is taken live.
  function automatic logic [23:0] pixel(input logic p, input logic [2:0] b,
                                        input logic [10:0] cx, input logic [10:0] cy,
                                        input logic [10:0] bx, input logic [23:0] col);
    logic in_x, in_y;
    in_x = ({1'b0, cx} >= {1'b0, bx}) && ({1'b0, cx} < {1'b0, bx} + SIZE12);
    in_y = ({1'b0, cy} >= BOXY12) && ({1'b0, cy} < BOXY12 + SIZE12);
    if (!p)             pixel = bar_col(b);
    else if (in_x && in_y) pixel = col;
    else                pixel = 24'h000000;
  endfunction

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      bar_cnt      <= '0;
      bar_idx      <= '0;
      cbeat        <= '0;
      gap_cnt      <= '0;
      box_x        <= '0;
      pat          <= 1'b0;
      frame_count  <= '0;
      source_data  <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt_state;
      x            <= nxt_x;
      y            <= nxt_y;
      bar_cnt      <= nxt_bar_cnt;
      bar_idx      <= nxt_bar_idx;
      cbeat        <= nxt_cbeat;
      gap_cnt      <= nxt_gap_cnt;
      box_x        <= nxt_box_x;
      pat          <= nxt_pat;
      frame_count  <= nxt_frame_count;
      source_data  <= nxt_data;
      source_valid <= nxt_valid;
      source_sop   <= nxt_sop;
      source_eop   <= nxt_eop;
      busy         <= nxt_busy;
    end
  end

  // Next state and next beat; outputs only move when idle or on a transfer.
  always_comb begin
    xfer            = source_valid & source_ready;
    nxt_state       = state;
    nxt_x           = x;
    nxt_y           = y;
    nxt_bar_cnt     = bar_cnt;
    nxt_bar_idx     = bar_idx;
    nxt_cbeat       = cbeat;
    nxt_gap_cnt     = gap_cnt;
    nxt_box_x       = box_x;
    nxt_pat         = pat;
    nxt_frame_count = frame_count;
    nxt_data        = source_data;
    nxt_valid       = source_valid;
    nxt_sop         = source_sop;
    nxt_eop         = source_eop;

    pbar_cnt = bar_cnt + 11'd1;
    pbar_idx = bar_idx;
    if (x == XMAX) begin
      px       = '0;
      py       = y + 11'd1;
      pbar_cnt = '0;
      pbar_idx = '0;
    end else begin
      px = x + 11'd1;
      py = y;
      if (bar_cnt == BARM) begin
        pbar_cnt = '0;
        pbar_idx = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end
    end
    bx_step = {1'b0, box_x} + STEP12;

    case (state)
      IDLE: if (enable) begin
        nxt_pat   = pattern_sel;
        nxt_valid = 1'b1;
        nxt_sop   = 1'b1;
        nxt_eop   = 1'b0;
`ifdef VID_CTRL_PKT_EN
        nxt_state = CTRL_HDR;
        nxt_data  = 24'h00000F;
`else
        nxt_state = VID_HDR;
        nxt_data  = 24'h000000;
`endif
      end
`ifdef VID_CTRL_PKT_EN
      CTRL_HDR: if (xfer) begin
        nxt_state = CTRL_DATA;
        nxt_cbeat = 2'd0;
        nxt_data  = ctrl_beat(2'd0);
        nxt_sop   = 1'b0;
      end
      CTRL_DATA: if (xfer) begin
        if (cbeat == 2'd2) begin
          nxt_state = VID_HDR;
          nxt_data  = 24'h000000;
          nxt_sop   = 1'b1;
          nxt_eop   = 1'b0;
        end else begin
          nxt_cbeat = cbeat + 2'd1;
          nxt_data  = ctrl_beat(cbeat + 2'd1);
          nxt_eop   = (cbeat == 2'd1);
        end
      end
`endif
      VID_HDR: if (xfer) begin
        nxt_state   = VID_PIX;
        nxt_x       = '0;
        nxt_y       = '0;
        nxt_bar_cnt = '0;
        nxt_bar_idx = '0;
        nxt_data    = pixel(pat, 3'd0, 11'd0, 11'd0, box_x, box_col);
        nxt_sop     = 1'b0;
        nxt_eop     = (XMAX == 11'd0) && (YMAX == 11'd0);
      end
      VID_PIX: if (xfer) begin
        if (x == XMAX && y == YMAX) begin
          nxt_state       = GAP;
          nxt_gap_cnt     = '0;
          nxt_valid       = 1'b0;
          nxt_eop         = 1'b0;
          nxt_data        = '0;
          nxt_frame_count = frame_count + 16'd1;
          nxt_box_x       = (bx_step > BOX_LIM) ? 11'd0 : bx_step[10:0];
        end else begin
          nxt_x       = px;
          nxt_y       = py;
          nxt_bar_cnt = pbar_cnt;
          nxt_bar_idx = pbar_idx;
          nxt_data    = pixel(pat, pbar_idx, px, py, box_x, box_col);
          nxt_eop     = (px == XMAX) && (py == YMAX);
        end
      end
      GAP: begin
        if (gap_cnt == GAPM) nxt_state = IDLE;
        else                 nxt_gap_cnt = gap_cnt + 16'd1;
      end
      default: nxt_state = IDLE;
    endcase

    nxt_busy = (nxt_state != IDLE);
  end

endmodule
